multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the MIPS-subset datapath (addu, subu, ori, lw, sw, beq, lui, jal, jr, nop). It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine so that one ALU, one memory port and the GRF write port are shared across cycles. It sits beside the IR, decodes its opcode and funct fields, and drives every datapath enable and mux select. It stalls in MEM on a data-memory ready handshake.

---
 rtl/multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Sequencing controller for a multi-cycle MIPS-subset datapath
// (addu, subu, ori, lw, sw, beq, lui, jal, jr, nop). A FETCH / DECODE /
// EXEC / MEM / WB state machine shares one ALU, one memory port and the
// register-file write port across cycles. It decodes the IR opcode and
// funct fields and drives every datapath enable and mux select.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   op_code[5:0] in   IR[31:26]
//   funct[5:0]   in   IR[5:0]
//   alu_is0      in   ALU result is zero (used by beq in EXEC)
//   mem_ready    in   data memory completes the access this cycle
//   ir_we/pc_we  out  IR load / PC load
//   npc_op[2:0]  out  000 PC+4, 001 branch, 010 jal target, 011 jr
//   alu_op[2:0]  out  000 add, 001 sub, 010 or
//   ext_op[1:0]  out  00 zero, 01 sign, 10 lui
//   grf_we/DM_we out  register-file write / data-memory write
//   mux_grf_a3   out  00 rd, 01 rt, 10 $31
//   mux_grf_wd   out  000 ALUOut, 001 MDR, 010 ext, 011 PC
//   mux_alu_in2  out  00 rt data, 01 ext
//   state[2:0]   out  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4
//   instr_done   out  pulse on the last cycle of each instruction
//   illegal      out  pulse in DECODE for an unrecognised encoding
//   instr_cnt    out  retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  op_code,
  input  logic [5:0]  funct,
  input  logic        alu_is0,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [2:0]  npc_op,
  output logic [2:0]  alu_op,
  output logic [1:0]  ext_op,
  output logic        grf_we,
  output logic        DM_we,
  output logic [1:0]  mux_grf_a3,
  output logic [2:0]  mux_grf_wd,
  output logic [1:0]  mux_alu_in2,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_instr_cnt;

  // Instruction decode
  logic w_rtype, w_addu, w_subu, w_nop, w_jr;
  logic w_ori, w_lw, w_sw, w_beq, w_lui, w_jal, w_legal;

  assign w_rtype = (op_code == 6'h00);
  assign w_addu  = w_rtype && (funct == 6'h21);
  assign w_subu  = w_rtype && (funct == 6'h23);
  assign w_nop   = w_rtype && (funct == 6'h00);
  assign w_jr    = w_rtype && (funct == 6'h08);
  assign w_ori   = (op_code == 6'h0d);
  assign w_lw    = (op_code == 6'h23);
  assign w_sw    = (op_code == 6'h2b);
  assign w_beq   = (op_code == 6'h04);
  assign w_lui   = (op_code == 6'h0f);
  assign w_jal   = (op_code == 6'h03);
  assign w_legal = w_addu | w_subu | w_nop | w_jr | w_ori | w_lw |
                   w_sw | w_beq | w_lui | w_jal;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_jal || w_jr || w_nop || !w_legal) w_next = S_FETCH;
        else                                     w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_lw || w_sw)                          w_next = S_MEM;
        else if (w_addu || w_subu || w_ori || w_lui) w_next = S_WB;
        else                                         w_next = S_FETCH;
      end
      S_MEM: begin
        if (!mem_ready) w_next = S_MEM;
        else if (w_lw)  w_next = S_WB;
        else            w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Output logic (enables are gated by reset further below)
  logic w_ir_we, w_pc_we, w_grf_we, w_dm_we, w_done, w_illegal;

  always_comb begin
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_grf_we    = 1'b0;
    w_dm_we     = 1'b0;
    w_done      = 1'b0;
    w_illegal   = 1'b0;
    npc_op      = 3'b000;
    alu_op      = 3'b000;
    ext_op      = 2'b00;
    mux_grf_a3  = 2'b00;
    mux_grf_wd  = 3'b000;
    mux_alu_in2 = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_ir_we = 1'b1;
        w_pc_we = 1'b1;
      end
      S_DECODE: begin
        if (w_jal) begin
          // PC already holds PC+4, so it is the link value written to $31
          w_pc_we    = 1'b1;
          npc_op     = 3'b010;
          w_grf_we   = 1'b1;
          mux_grf_a3 = 2'b10;
          mux_grf_wd = 3'b011;
          w_done     = 1'b1;
        end else if (w_jr) begin
          w_pc_we = 1'b1;
          npc_op  = 3'b011;
          w_done  = 1'b1;
        end else if (w_nop) begin
          w_done = 1'b1;
        end else if (!w_legal) begin
          w_illegal = 1'b1;
          w_done    = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_subu || w_beq) alu_op = 3'b001;
        else if (w_ori)      alu_op = 3'b010;
        if (w_ori || w_lw || w_sw) mux_alu_in2 = 2'b01;
        if (w_lw || w_sw || w_beq) ext_op = 2'b01;
        else if (w_lui)            ext_op = 2'b10;
        if (w_beq) begin
          w_pc_we = alu_is0;
          npc_op  = 3'b001;
          w_done  = 1'b1;
        end
      end
      S_MEM: begin
        // Write is held until the memory accepts it
        if (w_sw) begin
          w_dm_we = 1'b1;
          w_done  = mem_ready;
        end
      end
      S_WB: begin
        w_grf_we = 1'b1;
        w_done   = 1'b1;
        if (w_ori || w_lw || w_lui) mux_grf_a3 = 2'b01;
        if (w_lw)       mux_grf_wd = 3'b001;
        else if (w_lui) mux_grf_wd = 3'b010;
      end
      default: ;
    endcase
  end

  // Reset must silence every enable at once, even though FETCH is the
  // reset state and would otherwise raise ir_we/pc_we.
  assign ir_we      = w_ir_we   & reset_n;
  assign pc_we      = w_pc_we   & reset_n;
  assign grf_we     = w_grf_we  & reset_n;
  assign DM_we      = w_dm_we   & reset_n;
  assign instr_done = w_done    & reset_n;
  assign illegal    = w_illegal & reset_n;

  // Retired-instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_instr_cnt <= 32'd0;
    else if (w_done) r_instr_cnt <= r_instr_cnt + 32'd1;
  end

  assign state     = r_state;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  op_code = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        alu_is0 = 1'b0;
  logic        mem_ready = 1'b1;
  logic        ir_we, pc_we, grf_we, DM_we, instr_done, illegal;
  logic [2:0]  npc_op, alu_op, mux_grf_wd, state;
  logic [1:0]  ext_op, mux_grf_a3, mux_alu_in2;
  logic [31:0] instr_cnt;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op_code(op_code), .funct(funct),
    .alu_is0(alu_is0), .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we),
    .npc_op(npc_op), .alu_op(alu_op), .ext_op(ext_op), .grf_we(grf_we),
    .DM_we(DM_we), .mux_grf_a3(mux_grf_a3), .mux_grf_wd(mux_grf_wd),
    .mux_alu_in2(mux_alu_in2), .state(state), .instr_done(instr_done),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pc;
    logic [2:0] npc, alu;
    logic [1:0] ext;
    logic       grf, dm;
    logic [1:0] a3;
    logic [2:0] wd;
    logic [1:0] in2;
    logic       dn, il;
  } exp_t;

  typedef struct {
    logic       rn;
    logic [5:0] op, fn;
    logic       z, mr;
    exp_t       e;
  } vec_t;

  typedef struct {
    exp_t        e;
    logic [31:0] cnt;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = 32'd0;
  int          row = 0;

  function automatic vec_t R(int rn, int op, int fn, int z, int mr,
                             int st, int ir, int pc, int npc, int alu, int ext,
                             int grf, int dm, int a3, int wd, int in2,
                             int dn, int il);
    vec_t v;
    v.rn = 1'(rn); v.op = 6'(op); v.fn = 6'(fn); v.z = 1'(z); v.mr = 1'(mr);
    v.e = {3'(st), 1'(ir), 1'(pc), 3'(npc), 3'(alu), 2'(ext), 1'(grf),
           1'(dm), 2'(a3), 3'(wd), 2'(in2), 1'(dn), 1'(il)};
    return v;
  endfunction

  function automatic vec_t FET(int op, int fn);
    return R(1, op, fn, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t DEC(int op, int fn);
    return R(1, op, fn, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, then check it mid-cycle
  task automatic step(input vec_t v);
    sb_t  s;
    exp_t act;
    @(posedge clk);
    #1;
    reset_n   = v.rn;
    op_code   = v.op;
    funct     = v.fn;
    alu_is0   = v.z;
    mem_ready = v.mr;
    if (!v.rn) exp_cnt = 32'd0;
    sb.push_back('{v.e, exp_cnt});
    #3;
    s   = sb.pop_front();
    act = {state, ir_we, pc_we, npc_op, alu_op, ext_op, grf_we, DM_we,
           mux_grf_a3, mux_grf_wd, mux_alu_in2, instr_done, illegal};
    chk("outputs", 32'(act), 32'(s.e));
    chk("instr_cnt", instr_cnt, s.cnt);
    if (v.rn && s.e.dn) exp_cnt = exp_cnt + 32'd1;
    row++;
  endtask

  initial begin
    // rn op fn z mr | st ir pc npc alu ext grf dm a3 wd in2 dn il
    for (int i = 0; i < 3; i++)
      tbl.push_back(R(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // addu
    tbl.push_back(FET(0, 'h21)); tbl.push_back(DEC(0, 'h21));
    tbl.push_back(R(1, 0, 'h21, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(R(1, 0, 'h21, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    // subu
    tbl.push_back(FET(0, 'h23)); tbl.push_back(DEC(0, 'h23));
    tbl.push_back(R(1, 0, 'h23, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(R(1, 0, 'h23, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    // ori
    tbl.push_back(FET('h0d, 0)); tbl.push_back(DEC('h0d, 0));
    tbl.push_back(R(1, 'h0d, 0, 0, 1, 2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(R(1, 'h0d, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    // lui
    tbl.push_back(FET('h0f, 0)); tbl.push_back(DEC('h0f, 0));
    tbl.push_back(R(1, 'h0f, 0, 0, 1, 2, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(R(1, 'h0f, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 1, 0));
    // lw with two stalled MEM cycles
    tbl.push_back(FET('h23, 0)); tbl.push_back(DEC('h23, 0));
    tbl.push_back(R(1, 'h23, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(R(1, 'h23, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(R(1, 'h23, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(R(1, 'h23, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(R(1, 'h23, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0));
    // sw, ready at once
    tbl.push_back(FET('h2b, 0)); tbl.push_back(DEC('h2b, 0));
    tbl.push_back(R(1, 'h2b, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(R(1, 'h2b, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    // sw, one wait cycle
    tbl.push_back(FET('h2b, 0)); tbl.push_back(DEC('h2b, 0));
    tbl.push_back(R(1, 'h2b, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(R(1, 'h2b, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(R(1, 'h2b, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    // beq taken, then not taken
    tbl.push_back(FET('h04, 0)); tbl.push_back(DEC('h04, 0));
    tbl.push_back(R(1, 'h04, 0, 1, 1, 2, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(FET('h04, 0)); tbl.push_back(DEC('h04, 0));
    tbl.push_back(R(1, 'h04, 0, 0, 1, 2, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    // jal then jr
    tbl.push_back(FET('h03, 0));
    tbl.push_back(R(1, 'h03, 0, 0, 1, 1, 0, 1, 2, 0, 0, 1, 0, 2, 3, 0, 1, 0));
    tbl.push_back(FET(0, 'h08));
    tbl.push_back(R(1, 0, 'h08, 0, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // nop
    tbl.push_back(FET(0, 0));
    tbl.push_back(R(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // illegal opcode 3f and illegal R-type funct 01
    tbl.push_back(FET('h3f, 0));
    tbl.push_back(R(1, 'h3f, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(FET(0, 'h01));
    tbl.push_back(R(1, 0, 'h01, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(FET(0, 'h21));

    foreach (tbl[i]) step(tbl[i]);

    // Reset asserted while sw is stalled in MEM
    step(DEC('h2b, 0));
    step(R(1, 'h2b, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    step(R(1, 'h2b, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("sw stall DM_we", 32'(DM_we), 32'd1);
    chk("sw stall state", 32'(state), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("reset DM_we", 32'(DM_we), 32'd0);
    chk("reset state", 32'(state), 32'd0);
    chk("reset ir_we", 32'(ir_we), 32'd0);
    chk("reset instr_cnt", instr_cnt, 32'd0);
    step(R(0, 'h2b, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Restart with a nop from FETCH
    step(FET(0, 0));
    step(R(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(FET(0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
